// File: rtl/pipeline_scheduler.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory freeze, mul/div occupancy,
// branch redirect and load-use hazards. Optional counters under HAZ_PERF_CNT_EN.
module pipeline_scheduler #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic [4:0]       ID_EX_Rt,
    input  logic             ID_EX_memRead,
    input  logic             branchTaken,
    input  logic             mdStart,
    input  logic             dmemReq,
    input  logic             dmemReady,
    output logic [4:0]       stall,
    output logic             flushIF,
    output logic             flushID,
    output logic             nop,
    output logic             mdBusy,
    output logic             mdDone,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    if (MD_LATENCY < 1 || MD_LATENCY > 15 || CNT_W < 1) begin : g_param_check
        $error("pipeline_scheduler: MD_LATENCY must be 1..15 and CNT_W >= 1");
    end

    state_t     state, state_nxt, eff_state;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       ret_md, ret_md_nxt;
    logic       md_done_nxt;
    logic       hold;
    logic       load_use;

    // dmemReq/dmemReady: a data-memory access is in flight while dmemReq is high and
    // completes on the first cycle dmemReady is high; every earlier cycle freezes the pipe.
    always_comb begin
        hold      = (state == MEM_WAIT) ? ~dmemReady : (dmemReq & ~dmemReady);
        eff_state = state;
        if (state == MEM_WAIT)
            eff_state = ret_md ? MD_WAIT : RUN;
        load_use = ID_EX_memRead && (ID_EX_Rt != 5'd0) &&
                   ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
    end

    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        ret_md_nxt  = ret_md;
        md_done_nxt = 1'b0;
        stall       = 5'b00000;
        flushIF     = 1'b0;
        flushID     = 1'b0;
        nop         = 1'b0;

        if (hold) begin
            stall     = 5'b11111;
            state_nxt = MEM_WAIT;
            if (state != MEM_WAIT)
                ret_md_nxt = (state == MD_WAIT);
        end else begin
            case (eff_state)
                MD_WAIT: begin
                    stall      = 5'b00111;
                    nop        = 1'b1;
                    md_cnt_nxt = md_cnt - 4'd1;
                    if (md_cnt == 4'd1) begin
                        state_nxt   = RUN;
                        md_done_nxt = 1'b1;
                    end else begin
                        state_nxt = MD_WAIT;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    if (branchTaken) begin
                        flushIF = 1'b1;
                        flushID = 1'b1;
                    end else if (load_use) begin
                        stall   = 5'b00011;
                        flushID = 1'b1;
                        nop     = 1'b1;
                    end
                    // The branch is older than the flushed instructions, so its mul/div still runs.
                    if (mdStart) begin
                        md_cnt_nxt = MD_LOAD;
                        if (MD_LATENCY == 1)
                            md_done_nxt = 1'b1;
                        else
                            state_nxt = MD_WAIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= RUN;
            md_cnt <= 4'd0;
            ret_md <= 1'b0;
            mdDone <= 1'b0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            ret_md <= ret_md_nxt;
            mdDone <= md_done_nxt;
        end
    end

    // A freeze taken out of MD_WAIT keeps the unit busy until it resumes.
    assign mdBusy    = (state == MD_WAIT) || ((state == MEM_WAIT) && ret_md);
    assign dbg_state = state;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if ((stall != 5'b00000) && (stallCycles != '1))
                stallCycles <= stallCycles + 1'b1;
            if (flushIF && (flushCount != '1))
                flushCount <= flushCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_scheduler.sv
// Bench for pipeline_scheduler: directed scenarios plus randomized cycles checked
// against a cycle-count reference model.
module tb_pipeline_scheduler;

    localparam int L = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
    logic        ID_EX_memRead, branchTaken, mdStart, dmemReq, dmemReady;
    logic [4:0]  stall;
    logic        flushIF, flushID, nop, mdBusy, mdDone;
    logic [1:0]  dbg_state;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stallCycles, flushCount;
`endif

    int checks   = 0;
    int failures = 0;

    pipeline_scheduler #(.MD_LATENCY(L), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_EX_Rt(ID_EX_Rt),
        .ID_EX_memRead(ID_EX_memRead), .branchTaken(branchTaken), .mdStart(mdStart),
        .dmemReq(dmemReq), .dmemReady(dmemReady),
        .stall(stall), .flushIF(flushIF), .flushID(flushID), .nop(nop),
        .mdBusy(mdBusy), .mdDone(mdDone),
`ifdef HAZ_PERF_CNT_EN
        .stallCycles(stallCycles), .flushCount(flushCount),
`endif
        .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    wire [9:0] obs = {stall, flushIF, flushID, nop, mdBusy, mdDone};

    function automatic logic [9:0] ev(input logic [4:0] s, input logic fi, input logic fd,
                                      input logic n, input logic b, input logic d);
        return {s, fi, fd, n, b, d};
    endfunction

    task automatic set_idle();
        IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_EX_Rt = 5'd0; ID_EX_memRead = 1'b0;
        branchTaken = 1'b0; mdStart = 1'b0; dmemReq = 1'b0; dmemReady = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        Rst = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [9:0] e;
        // Assert reset mid-cycle with random inputs.
        IF_ID_Rs = 5'($urandom_range(0, 31)); IF_ID_Rt = 5'($urandom_range(0, 31));
        ID_EX_Rt = 5'($urandom_range(0, 31)); ID_EX_memRead = 1'($urandom_range(0, 1));
        branchTaken = 1'($urandom_range(0, 1)); mdStart = 1'($urandom_range(0, 1));
        dmemReq = 1'($urandom_range(0, 1)); dmemReady = 1'($urandom_range(0, 1));
        #2 Rst = 1'b0;
        #1;
        checks++;
        if ({dbg_state, mdBusy, mdDone} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_assert obs=%b exp=0000", {dbg_state, mdBusy, mdDone});
        end
        tick();
        set_idle();
        tick();
        Rst = 1'b1;
        tick();
        e = ev(5'b00000, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_idle obs=%b state=%0d exp=%b state=0", obs, dbg_state, e);
        end
        // Reset in the middle of a mul/div wait aborts to RUN.
        mdStart = 1'b1; tick(); mdStart = 1'b0; tick();
        #2 Rst = 1'b0;
        #1;
        checks++;
        if ({dbg_state, mdBusy, mdDone} !== 4'b0000 || obs !== 10'd0) begin
            failures++;
            $display("FAIL reset_mid_md obs=%b state=%0d exp=0 state=0", obs, dbg_state);
        end
        tick();
        Rst = 1'b1;
        tick();
        // Reset in the middle of a freeze taken out of MD_WAIT.
        mdStart = 1'b1; tick(); mdStart = 1'b0;
        dmemReq = 1'b1; tick(); tick();
        #2 Rst = 1'b0;
        #1;
        checks++;
        if ({dbg_state, mdBusy, mdDone} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_mem obs=%b exp=0000", {dbg_state, mdBusy, mdDone});
        end
        set_idle();
        tick();
        Rst = 1'b1;
        tick();
        checks++;
        if (obs !== 10'd0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_release obs=%b state=%0d exp=0 state=0", obs, dbg_state);
        end
    endtask

    task automatic test_load_use();
        logic [9:0] e;
        e = ev(5'b00011, 0, 1, 1, 0, 0);
        ID_EX_memRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5; IF_ID_Rt = 5'd9;
        #1;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL load_use_rs obs=%b exp=%b", obs, e);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (obs !== 10'd0) begin
            failures++;
            $display("FAIL load_use_one_cycle obs=%b exp=0", obs);
        end
        ID_EX_memRead = 1'b1; ID_EX_Rt = 5'd17; IF_ID_Rs = 5'd2; IF_ID_Rt = 5'd17;
        #1;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL load_use_rt obs=%b exp=%b", obs, e);
        end
        tick();
        ID_EX_memRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0;
        #1;
        checks++;
        if (obs !== 10'd0) begin
            failures++;
            $display("FAIL load_use_r0 obs=%b exp=0", obs);
        end
        tick();
        set_idle();
    endtask

    task automatic test_branch();
        logic [9:0] e;
        e = ev(5'b00000, 1, 1, 0, 0, 0);
        ID_EX_memRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5; branchTaken = 1'b1;
        #1;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL branch_over_load_use obs=%b exp=%b", obs, e);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (obs !== 10'd0) begin
            failures++;
            $display("FAIL branch_after obs=%b exp=0", obs);
        end
    endtask

    task automatic test_mul_div();
        logic [9:0] exp_seq [6];
        exp_seq[0] = ev(5'b00000, 0, 0, 0, 0, 0);
        exp_seq[1] = ev(5'b00111, 0, 0, 1, 1, 0);
        exp_seq[2] = ev(5'b00111, 0, 0, 1, 1, 0);
        exp_seq[3] = ev(5'b00111, 0, 0, 1, 1, 0);
        exp_seq[4] = ev(5'b00000, 0, 0, 0, 0, 1);
        exp_seq[5] = ev(5'b00000, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            set_idle();
            mdStart = (c == 0);
            #1;
            checks++;
            if (obs !== exp_seq[c]) begin
                failures++;
                $display("FAIL mul_div cyc%0d obs=%b exp=%b", c, obs, exp_seq[c]);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_freeze_in_md();
        logic [9:0] exp_seq [8];
        exp_seq[0] = ev(5'b00000, 0, 0, 0, 0, 0);
        exp_seq[1] = ev(5'b00111, 0, 0, 1, 1, 0);
        exp_seq[2] = ev(5'b11111, 0, 0, 0, 1, 0);
        exp_seq[3] = ev(5'b11111, 0, 0, 0, 1, 0);
        exp_seq[4] = ev(5'b00111, 0, 0, 1, 1, 0);
        exp_seq[5] = ev(5'b00111, 0, 0, 1, 1, 0);
        exp_seq[6] = ev(5'b00000, 0, 0, 0, 0, 1);
        exp_seq[7] = ev(5'b00000, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            set_idle();
            mdStart   = (c == 0);
            branchTaken = (c == 2 || c == 3);
            dmemReq   = (c >= 2 && c <= 4);
            dmemReady = (c == 4);
            #1;
            checks++;
            if (obs !== exp_seq[c]) begin
                failures++;
                $display("FAIL freeze_in_md cyc%0d obs=%b exp=%b", c, obs, exp_seq[c]);
            end
            tick();
        end
        set_idle();
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf_counters();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_idle();
            mdStart = (c == 0);
            tick();
        end
        branchTaken = 1'b1;
        tick();
        set_idle();
        tick();
        checks++;
        if (stallCycles !== 16'd3 || flushCount !== 16'd1) begin
            failures++;
            $display("FAIL perf_counters stallCycles=%0d flushCount=%0d exp 3 and 1",
                     stallCycles, flushCount);
        end
    endtask
`endif

    // Reference model: tracks remaining busy cycles of an outstanding mul/div, whether a
    // memory access is still pending, and whether a completion pulse is due next cycle.
    task automatic test_random(input int n);
        int         busy_left;
        bit         mem_wait, done_q, done_n, frozen, lu;
        logic [4:0] e_stall;
        logic       e_fi, e_fd, e_nop, e_busy, e_done;
        logic [9:0] e;
        busy_left = 0; mem_wait = 0; done_q = 0;
        do_reset();
        for (int c = 0; c < n; c++) begin
            IF_ID_Rs      = 5'($urandom_range(0, 3));
            IF_ID_Rt      = 5'($urandom_range(0, 3));
            ID_EX_Rt      = 5'($urandom_range(0, 3));
            ID_EX_memRead = ($urandom_range(0, 2) == 0);
            branchTaken   = ($urandom_range(0, 5) == 0);
            mdStart       = ($urandom_range(0, 5) == 0);
            dmemReq       = mem_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
            dmemReady     = ($urandom_range(0, 2) == 0);

            frozen  = mem_wait ? !dmemReady : (dmemReq && !dmemReady);
            e_stall = 5'b00000; e_fi = 0; e_fd = 0; e_nop = 0;
            e_busy  = (busy_left > 0);
            e_done  = done_q;
            done_n  = 0;
            if (frozen) begin
                e_stall  = 5'b11111;
                mem_wait = 1;
            end else begin
                mem_wait = 0;
                if (busy_left > 0) begin
                    e_stall = 5'b00111;
                    e_nop   = 1;
                    busy_left--;
                    done_n  = (busy_left == 0);
                end else begin
                    lu = ID_EX_memRead && ID_EX_Rt != 0 &&
                         (ID_EX_Rt == IF_ID_Rs || ID_EX_Rt == IF_ID_Rt);
                    if (branchTaken) begin
                        e_fi = 1; e_fd = 1;
                    end else if (lu) begin
                        e_stall = 5'b00011; e_fd = 1; e_nop = 1;
                    end
                    if (mdStart) begin
                        if (L == 1) done_n = 1;
                        else        busy_left = L - 1;
                    end
                end
            end
            e = ev(e_stall, e_fi, e_fd, e_nop, e_busy, e_done);
            #1;
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL random cyc%0d obs=%b exp=%b", c, obs, e);
            end
            done_q = done_n;
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        test_reset();
        test_load_use();
        test_branch();
        test_mul_div();
        test_freeze_in_md();
`ifdef HAZ_PERF_CNT_EN
        test_perf_counters();
`endif
        test_random(500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_scheduler.md
# pipeline_scheduler

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges load-use hazards, taken-branch redirects, multi-cycle multiply/divide occupancy and data-memory wait states into one prioritised set of per-stage stall, flush and bubble controls. It sits beside the decode stage and drives the pipeline-register enables and the control-mux NOP select.

## Interface
- `MD_LATENCY`, default 4: EX-stage cycles a mul/div occupies; legal range 1..15.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `Clk`  in  1  pipeline clock, rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `IF_ID_Rs`, `IF_ID_Rt`  in  5 each  source registers of the instruction in decode.
- `ID_EX_Rt`  in  5  destination of the instruction in EX when it is a load.
- `ID_EX_memRead`  in  1  instruction in EX is a load.
- `branchTaken`  in  1  branch/jump resolved taken in EX.
- `mdStart`  in  1  mul/div instruction present in EX.
- `dmemReq`  in  1  MEM stage is accessing data memory.
- `dmemReady`  in  1  data memory completes this cycle.
- `stall`  out  5  per-stage hold: [4] MEM_WB, [3] EX_MEM, [2] ID_EX, [1] IF_ID, [0] PC.
- `flushIF`  out  1  clears IF_ID.
- `flushID`  out  1  clears ID_EX.
- `nop`  out  1  forces decoded control signals to zero.
- `mdBusy`  out  1  asserted while in MD_WAIT.
- `mdDone`  out  1  one-cycle pulse when the mul/div result is valid.

## Operation
- FSM states are RUN, MD_WAIT and MEM_WAIT. MEM_WAIT holds a registered return flag (`retMd`) and a 4-bit down-counter `mdCnt`.
- **Freeze.** `frz = dmemReq & ~dmemReady`.
  - In any state, `frz` forces `stall=5'b11111`, `flushIF=flushID=nop=0`.
  - All other events are suppressed; `mdCnt` holds.
  - The FSM moves to MEM_WAIT. `retMd` is set if the FSM came from MD_WAIT.
- **MEM_WAIT.** Freeze outputs persist while `~dmemReady`. On `dmemReady` the FSM returns to RUN, or to MD_WAIT when `retMd=1`. That cycle's outputs are evaluated as in the destination state.
- **Branch (RUN, no freeze).** `branchTaken` gives `flushIF=1`, `flushID=1`, `stall=0`. It overrides load-use. A simultaneous `mdStart` does start MD_WAIT, because the branch is older than the instructions being flushed.
- **Mul/div (RUN, no freeze).** `mdStart` loads `mdCnt=MD_LATENCY-1`.
  - If `MD_LATENCY==1`: stay in RUN and pulse `mdDone` next cycle.
  - Otherwise: enter MD_WAIT.
- **MD_WAIT.** Outputs are `stall=5'b00111`, `nop=1` (bubble into EX_MEM) and `mdBusy=1`. `mdCnt` decrements each unfrozen cycle. At `mdCnt==1` it goes to RUN with `mdDone=1` in the first RUN cycle. `mdStart` and `branchTaken` are ignored inside MD_WAIT.
- **Load-use (RUN, no freeze, no branch).** The condition is `ID_EX_memRead & ID_EX_Rt!=0 & (ID_EX_Rt==IF_ID_Rs | ID_EX_Rt==IF_ID_Rt)`. It gives `stall=5'b00011`, `flushID=1`, `nop=1` for exactly the cycle it is true.
- **Priority:** freeze > MD_WAIT > branch > load-use.

## Timing
- `stall`, `flushIF`, `flushID` and `nop` are combinational (Mealy) from state plus same-cycle inputs, with no added latency. State, `mdCnt`, `retMd`, `mdDone` and the counters are registered.
- Reset is asynchronous on `Rst` low: state=RUN, `mdCnt=0`, `retMd=0`, `mdDone=0`, counters=0.
  - With idle inputs all outputs are 0.
  - Reset mid-MD_WAIT or mid-MEM_WAIT aborts to RUN immediately.
- Mul/div with no freeze: `mdBusy` lasts `MD_LATENCY-1` cycles after the `mdStart` cycle, and `mdDone` fires `MD_LATENCY` cycles after `mdStart`.
- A freeze adds exactly its length to that figure.
- `mdDone` never coincides with `mdBusy`.

## Configuration
- `HAZ_PERF_CNT_EN` defined: the block adds outputs `stallCycles[CNT_W-1:0]` and `flushCount[CNT_W-1:0]`.
  - `stallCycles` increments on every cycle with `stall!=0`.
  - `flushCount` increments on every cycle with `flushIF=1`.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither port nor register exists, and behaviour is otherwise identical.

## Test plan
- **Reset.** Stimulus: drop `Rst` with random inputs, then release with idle inputs. Required: all outputs 0 and state RUN.
- **Load-use.** Stimulus: `ID_EX_memRead=1`, `ID_EX_Rt=5`, `IF_ID_Rs=5` for one cycle. Required: `stall=00011`, `flushID=1`, `nop=1` that cycle only. The same stimulus with `ID_EX_Rt=0` gives all outputs 0.
- **Branch.** Stimulus: `branchTaken=1` together with the load-use condition. Required: `flushIF=flushID=1`, `stall=0`, `nop=0`.
- **Mul/div.** Stimulus: `MD_LATENCY=4`, `mdStart` at cycle 0. Required: `mdBusy` and `stall=00111` during cycles 1–3, `mdDone` pulse at cycle 4.
- **Freeze inside MD_WAIT.** Stimulus: same as the mul/div case, plus `dmemReq=1`, `dmemReady=0` during cycles 2–3. Required: `stall=11111` during cycles 2–3, MD_WAIT resumes, `mdDone` at cycle 6.
- **Performance counters.** Stimulus: `HAZ_PERF_CNT_EN` defined, run the mul/div scenario plus one branch. Required: `stallCycles=3`, `flushCount=1`.
